// File: rtl/mul_div_unit.sv
// Multi-cycle multiply/divide unit with architectural HI/LO registers.
// The arithmetic is combinational on the captured operands. The busy-cycle
// counter only decides when HI/LO take the result.
module mul_div_unit #(
  parameter int WIDTH       = 32,
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] HI,
  output logic [WIDTH-1:0] LO
);

  localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int CW         = $clog2(MAX_CYCLES + 1);

  localparam logic [CW-1:0] CNT_ONE  = CW'(1);
  localparam logic [CW-1:0] CNT_MULT = CW'(MULT_CYCLES);
  localparam logic [CW-1:0] CNT_DIV  = CW'(DIV_CYCLES);

  typedef enum logic {
    IDLE,
    BUSY
  } state_t;

  state_t             state;
  logic [CW-1:0]      count;
  logic [1:0]         op_q;
  logic [WIDTH-1:0]   a_q;
  logic [WIDTH-1:0]   b_q;

  logic               is_signed;
  logic [2*WIDTH-1:0] ext_a;
  logic [2*WIDTH-1:0] ext_b;
  logic [2*WIDTH-1:0] product;
  logic               a_neg;
  logic               b_neg;
  logic [WIDTH-1:0]   a_mag;
  logic [WIDTH-1:0]   b_mag;
  logic [WIDTH-1:0]   q_mag;
  logic [WIDTH-1:0]   r_mag;
  logic [WIDTH-1:0]   quot;
  logic [WIDTH-1:0]   rem;
  logic               div_zero;

  // Result datapath. Signed division runs on magnitudes and then fixes the signs.
  // This makes most-negative / -1 wrap back to most-negative with a zero remainder.
  always_comb begin
    is_signed = ~op_q[0];
    ext_a     = {{WIDTH{is_signed & a_q[WIDTH-1]}}, a_q};
    ext_b     = {{WIDTH{is_signed & b_q[WIDTH-1]}}, b_q};
    product   = ext_a * ext_b;
    a_neg     = is_signed & a_q[WIDTH-1];
    b_neg     = is_signed & b_q[WIDTH-1];
    a_mag     = a_neg ? -a_q : a_q;
    b_mag     = b_neg ? -b_q : b_q;
    div_zero  = (b_q == '0);
    q_mag     = '0;
    r_mag     = '0;
    if (!div_zero) begin
      q_mag = a_mag / b_mag;
      r_mag = a_mag % b_mag;
    end
    quot = (a_neg ^ b_neg) ? -q_mag : q_mag;
    rem  = a_neg ? -r_mag : r_mag;
  end

  // Control FSM with registered busy/done. HI/LO are written here.
  // They change on move-to writes, or when the counter expires (except on divide by zero).
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      count <= '0;
      op_q  <= '0;
      a_q   <= '0;
      b_q   <= '0;
      busy  <= 1'b0;
      done  <= 1'b0;
      HI    <= '0;
      LO    <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            if (op <= 3'd3) begin
              op_q  <= op[1:0];
              a_q   <= A;
              b_q   <= B;
              count <= op[1] ? CNT_DIV : CNT_MULT;
              busy  <= 1'b1;
              state <= BUSY;
            end else if (op == 3'd4) begin
              HI <= A;
            end else if (op == 3'd5) begin
              LO <= A;
            end
          end
        end
        BUSY: begin
          count <= count - CNT_ONE;
          if (count == CNT_ONE) begin
            busy  <= 1'b0;
            done  <= 1'b1;
            state <= IDLE;
            if (!op_q[1]) begin
              HI <= product[2*WIDTH-1:WIDTH];
              LO <= product[WIDTH-1:0];
            end else if (!div_zero) begin
              HI <= rem;
              LO <= quot;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mul_div_unit.sv
// Self-checking bench for mul_div_unit. It uses directed cases and then random operations.
// The expected results come from a plain-arithmetic HI/LO model kept in the bench.
module tb_mul_div_unit;

  localparam int WIDTH = 32;

  logic             clk = 1'b0;
  logic             reset;
  logic             start;
  logic [2:0]       opSel;
  logic [WIDTH-1:0] opA;
  logic [WIDTH-1:0] opB;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] HI;
  logic [WIDTH-1:0] LO;

  logic [31:0] refHi;
  logic [31:0] refLo;
  int          checkCount = 0;
  int          passCount  = 0;

  mul_div_unit #(.WIDTH(WIDTH), .MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
    .clk(clk), .reset(reset), .start(start), .op(opSel), .A(opA), .B(opB),
    .busy(busy), .done(done), .HI(HI), .LO(LO)
  );

  // Free-running clock with a 10 ns period.
  always #5 clk = ~clk;

  // Watchdog so the bench can never hang.
  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  // Single comparison point. It counts every check and reports mismatches.
  task automatic checkOutput(input string tag, input logic [63:0] actual, input logic [63:0] expected);
    checkCount++;
    if (actual === expected) passCount++;
    else $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
  endtask

  // Drives one start strobe so that the next rising edge samples it.
  // On return the bench is 1 ns past that edge.
  task automatic applyStimulus(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
    @(negedge clk);
    start = 1'b1;
    opSel = o;
    opA   = a;
    opB   = b;
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  // Reference model: MIPS-style HI/LO semantics computed with 64-bit arithmetic.
  function automatic void refExec(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
    longint      sa;
    longint      sb;
    longint      q;
    longint      r;
    logic [63:0] p;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    case (o)
      3'd0: begin p = sa * sb; refHi = p[63:32]; refLo = p[31:0]; end
      3'd1: begin p = {32'b0, a} * {32'b0, b}; refHi = p[63:32]; refLo = p[31:0]; end
      3'd2: if (b != 0) begin q = sa / sb; r = sa % sb; refLo = q[31:0]; refHi = r[31:0]; end
      3'd3: if (b != 0) begin refLo = a / b; refHi = a % b; end
      3'd4: refHi = a;
      3'd5: refLo = a;
      default: ;
    endcase
  endfunction

  function automatic int expCycles(input logic [2:0] o);
    if (o <= 3'd1) return 5;
    if (o <= 3'd3) return 10;
    return 0;
  endfunction

  // Called 1 ns after an accepting edge. It counts the busy cycles (the wait is bounded).
  // It scrambles A/B while waiting, then checks done and HI/LO against the model.
  task automatic waitResult(input int expected, input string tag);
    int cycles;
    cycles = 0;
    if (expected == 0) begin
      checkOutput({tag, "_busy"}, busy, 0);
      checkOutput({tag, "_done"}, done, 0);
    end else begin
      while (busy && cycles < 50) begin
        cycles++;
        opA = $urandom;
        opB = $urandom;
        @(posedge clk);
        #1;
      end
      checkOutput({tag, "_cycles"}, cycles, expected);
      checkOutput({tag, "_done"}, done, 1);
    end
    checkOutput({tag, "_hi"}, HI, refHi);
    checkOutput({tag, "_lo"}, LO, refLo);
  endtask

  // Full operation: issue it, update the model, wait, and check that done is one cycle wide.
  task automatic runOp(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b, input string tag);
    applyStimulus(o, a, b);
    refExec(o, a, b);
    waitResult(expCycles(o), tag);
    if (expCycles(o) > 0) begin
      @(posedge clk);
      #1;
      checkOutput({tag, "_done_drop"}, done, 0);
    end
  endtask

  // Main sequence: reset, directed cases, then randomized operations.
  initial begin
    int          doneSeen;
    logic [2:0]  rop;
    logic [31:0] ra;
    logic [31:0] rb;

    reset = 1'b1;
    start = 1'b0;
    opSel = '0;
    opA   = '0;
    opB   = '0;
    refHi = '0;
    refLo = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    checkOutput("reset_busy", busy, 0);
    checkOutput("reset_done", done, 0);
    checkOutput("reset_hi", HI, 0);
    checkOutput("reset_lo", LO, 0);

    runOp(3'd0, 32'hFFFFFFFF, 32'h00000002, "mult_neg1x2");
    checkOutput("mult_hi_const", HI, 32'hFFFFFFFF);
    checkOutput("mult_lo_const", LO, 32'hFFFFFFFE);
    runOp(3'd1, 32'hFFFFFFFF, 32'h00000002, "multu");
    checkOutput("multu_hi_const", HI, 32'h00000001);
    runOp(3'd2, 32'hFFFFFFF9, 32'h00000002, "div_m7_2");
    checkOutput("div_lo_const", LO, 32'hFFFFFFFD);
    checkOutput("div_hi_const", HI, 32'hFFFFFFFF);
    runOp(3'd2, 32'h80000000, 32'hFFFFFFFF, "div_min_m1");
    checkOutput("div_ovf_lo_const", LO, 32'h80000000);
    checkOutput("div_ovf_hi_const", HI, 32'h00000000);

    runOp(3'd4, 32'h12345678, 32'h0, "mthi");
    runOp(3'd5, 32'h9ABCDEF0, 32'h0, "mtlo");
    runOp(3'd3, 32'hDEADBEEF, 32'h0, "divu_zero");
    checkOutput("divu_zero_hi_const", HI, 32'h12345678);
    checkOutput("divu_zero_lo_const", LO, 32'h9ABCDEF0);
    runOp(3'd6, 32'hCAFEF00D, 32'h1, "nop6");

    // Starts issued while busy are ignored. A MULTU issued on the done cycle is accepted.
    applyStimulus(3'd0, 32'h00012345, 32'hFFFF0003);
    refExec(3'd0, 32'h00012345, 32'hFFFF0003);
    applyStimulus(3'd5, 32'h55555555, 32'h0);
    checkOutput("ign_busy_mid", busy, 1);
    applyStimulus(3'd2, 32'h00000100, 32'h00000003);
    waitResult(3, "ign_mult");
    applyStimulus(3'd1, 32'h80000001, 32'h00000010);
    refExec(3'd1, 32'h80000001, 32'h00000010);
    checkOutput("b2b_done_drop", done, 0);
    waitResult(5, "b2b_multu");

    // Asynchronous reset in the middle of a divide, asserted between clock edges.
    applyStimulus(3'd2, 32'h7FFFFFFF, 32'h00000007);
    repeat (2) @(posedge clk);
    #3;
    reset = 1'b1;
    #1;
    checkOutput("arst_busy", busy, 0);
    checkOutput("arst_done", done, 0);
    checkOutput("arst_hi", HI, 0);
    checkOutput("arst_lo", LO, 0);
    refHi = '0;
    refLo = '0;
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    doneSeen = 0;
    for (int i = 0; i < 15; i++) begin
      @(posedge clk);
      #1;
      if (done) doneSeen++;
    end
    checkOutput("arst_no_done", doneSeen, 0);
    checkOutput("arst_hi_after", HI, 0);
    checkOutput("arst_lo_after", LO, 0);

    // Randomized operations, with extra weight on zero divisors and overflow operands.
    for (int i = 0; i < 40; i++) begin
      rop = 3'($urandom_range(0, 7));
      ra  = $urandom;
      rb  = $urandom;
      case ($urandom_range(0, 7))
        0: rb = '0;
        1: begin ra = 32'h80000000; rb = 32'hFFFFFFFF; end
        2: rb = 32'($urandom_range(1, 9));
        default: ;
      endcase
      runOp(rop, ra, rb, $sformatf("rand%0d_op%0d", i, rop));
    end

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
